regfile: RTL and testbench



---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_if.sv | 34 +++
 rtl/transmitter.sv | 12 +
 rtl/regfile.sv | 104 ++++++++++
 tb/tb_regfile.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types for the general-purpose register file.
// Operation codes applied to the register selected by i_wrSel.
package regfile_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } op_e;

endpackage

// File: rtl/regfile_if.sv
// Control, select and read-data signals of the register file.
// The master drives selects and operations; the slave (regfile) returns read data and flags.
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   i_d;
    op_e                 i_op;
    logic                i_clear;
    logic [SEL_W-1:0]    i_wrSel;
    logic [SEL_W-1:0]    i_busSel;
    logic                i_busEn;
    logic [SEL_W-1:0]    i_aluSelA;
    logic [SEL_W-1:0]    i_aluSelB;
    logic [DATA_W-1:0]   o_aluA;
    logic [DATA_W-1:0]   o_aluB;
    logic                o_wrap;
    logic [NUM_REGS-1:0] o_zero;

    modport master (
        output i_d, i_op, i_clear, i_wrSel, i_busSel, i_busEn, i_aluSelA, i_aluSelB,
        input  o_aluA, o_aluB, o_wrap, o_zero
    );

    modport slave (
        input  i_d, i_op, i_clear, i_wrSel, i_busSel, i_busEn, i_aluSelA, i_aluSelB,
        output o_aluA, o_aluB, o_wrap, o_zero
    );

endinterface

// File: rtl/transmitter.sv
// Tri-state bus driver cell: drives a onto b while ce is high, releases b otherwise.
module transmitter #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output tri   [W-1:0] b,
    input  logic         ce
);

    assign b = ce ? a : {W{1'bz}};

endmodule

// File: rtl/regfile.sv
// Parametrised register file: two combinational ALU read ports, one tri-stated bus port,
// and one in-place load/inc/dec/clear per cycle with a registered wrap flag.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    regfile_if.slave          rf,
    output tri   [DATA_W-1:0] o_bus
);

    localparam int SEL_W  = $clog2(NUM_REGS);
    localparam int NUM_RD = 4;  // ALU A, ALU B, bus, current value of the write target

    logic [DATA_W-1:0] regs_reg [NUM_REGS];
    logic              wrap_reg;

    logic [SEL_W-1:0]  rd_sel [NUM_RD];
    logic              wr_valid;
    logic [DATA_W:0]   wr_res;   // {wrap, next value}

    assign rd_sel[0] = rf.i_aluSelA;
    assign rd_sel[1] = rf.i_aluSelB;
    assign rd_sel[2] = rf.i_busSel;
    assign rd_sel[3] = rf.i_wrSel;

    // Out-of-range selects (non-power-of-two depth) fall through to zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [DATA_W-1:0] data;
            always_comb begin
                data = '0;
                for (int n = 0; n < NUM_REGS; n++) begin
                    if (rd_sel[gi] == SEL_W'(n)) begin
                        data = regs_reg[n];
                    end
                end
            end
        end
    endgenerate

    function automatic logic [DATA_W:0] next_value(
        input op_e               op,
        input logic              clr,
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] d
    );
        logic [DATA_W:0] res;
        res = {1'b0, cur};
        if (clr) begin
            res = '0;
        end else begin
            case (op)
                OP_LOAD: res = {1'b0, d};
                OP_INC:  res = {(cur == {DATA_W{1'b1}}), cur + DATA_W'(1)};
                OP_DEC:  res = {(cur == '0), cur - DATA_W'(1)};
                default: res = {1'b0, cur};
            endcase
        end
        return res;
    endfunction

    assign wr_valid = {1'b0, rf.i_wrSel} < (SEL_W + 1)'(NUM_REGS);
    assign wr_res   = next_value(rf.i_op, rf.i_clear, g_rd[3].data, rf.i_d);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_reg[n] <= '0;
            end
            wrap_reg <= 1'b0;
        end else begin
            wrap_reg <= wr_valid && wr_res[DATA_W];
            for (int n = 0; n < NUM_REGS; n++) begin
                if (wr_valid && (rf.i_wrSel == SEL_W'(n))) begin
                    regs_reg[n] <= wr_res[DATA_W-1:0];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_zero
            assign rf.o_zero[gi] = (regs_reg[gi] == '0);
        end
    endgenerate

    assign rf.o_aluA = g_rd[0].data;
    assign rf.o_aluB = g_rd[1].data;
    assign rf.o_wrap = wrap_reg;

    transmitter #(
        .W (DATA_W)
    ) u_transmitter (
        .a  (g_rd[2].data),
        .b  (o_bus),
        .ce (rf.i_busEn)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: a 4-register and a 3-register instance share stimulus;
// an array model predicts every read port, bus, wrap and zero flag.
`timescale 1ns/1ps
module tb_regfile;
    import regfile_pkg::*;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] d;
    op_e           op;
    logic          clr;
    logic [1:0]    ws, sa, sb, bs;
    logic          be;

    regfile_if #(.DATA_W(DW), .NUM_REGS(4)) if4 ();
    regfile_if #(.DATA_W(DW), .NUM_REGS(3)) if3 ();

    // Pulled-up nets: a released bus reads as all ones.
    tri1 [DW-1:0] bus4;
    tri1 [DW-1:0] bus3;

    assign if4.i_d = d;      assign if3.i_d = d;
    assign if4.i_op = op;    assign if3.i_op = op;
    assign if4.i_clear = clr; assign if3.i_clear = clr;
    assign if4.i_wrSel = ws; assign if3.i_wrSel = ws;
    assign if4.i_busSel = bs; assign if3.i_busSel = bs;
    assign if4.i_busEn = be; assign if3.i_busEn = be;
    assign if4.i_aluSelA = sa; assign if3.i_aluSelA = sa;
    assign if4.i_aluSelB = sb; assign if3.i_aluSelB = sb;

    regfile #(.DATA_W(DW), .NUM_REGS(4)) dut4 (
        .i_clk(clk), .i_reset(rst), .rf(if4), .o_bus(bus4)
    );
    regfile #(.DATA_W(DW), .NUM_REGS(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .rf(if3), .o_bus(bus3)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] bus;
        logic       w;
        logic [3:0] z;
    } obs_t;

    typedef struct {
        obs_t o4;
        obs_t o3;
        int   id;
        bit   post;
    } exp_t;

    exp_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   txn = 0;

    // Reference model: index 0 is the 4-deep file, index 1 the 3-deep file.
    int unsigned m [2][4];
    bit          mw [2];
    int          nreg [2] = '{4, 3};

    function automatic int unsigned rd(int k, int sel);
        return (sel < nreg[k]) ? m[k][sel] : 0;
    endfunction

    function automatic obs_t model_obs(int k);
        obs_t o;
        o.a   = 8'(rd(k, int'(sa)));
        o.b   = 8'(rd(k, int'(sb)));
        o.bus = be ? 8'(rd(k, int'(bs))) : 8'hFF;
        o.w   = mw[k];
        for (int r = 0; r < 4; r++) o.z[r] = (r < nreg[k]) && (m[k][r] == 0);
        return o;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 4; r++) m[k][r] = 0;
                mw[k] = 0;
            end else if (int'(ws) >= nreg[k]) begin
                mw[k] = 0;
            end else if (clr) begin
                m[k][ws] = 0;
                mw[k] = 0;
            end else begin
                case (op)
                    OP_LOAD: begin m[k][ws] = d; mw[k] = 0; end
                    OP_INC:  begin mw[k] = (m[k][ws] == 255); m[k][ws] = (m[k][ws] + 1) % 256; end
                    OP_DEC:  begin mw[k] = (m[k][ws] == 0);   m[k][ws] = (m[k][ws] + 255) % 256; end
                    default: mw[k] = 0;
                endcase
            end
        end
    endtask

    task automatic push(bit post);
        exp_t e;
        e.o4 = model_obs(0);
        e.o3 = model_obs(1);
        e.id = txn;
        e.post = post;
        expq.push_back(e);
    endtask

    task automatic cycle(bit r, bit c, op_e o, int w, int dd, int a, int b, int s, bit e);
        @(negedge clk);
        rst = r; clr = c; op = o; ws = 2'(w); d = 8'(dd);
        sa = 2'(a); sb = 2'(b); bs = 2'(s); be = e;
        txn++;
        $display("txn %0d rst=%0b clr=%0b op=%s wr=%0d d=%02h selA=%0d selB=%0d bus=%0d en=%0b",
                 txn, r, c, o.name(), w, dd & 255, a, b, s, e);
        push(1'b0);   // before the edge: old state, new selects
        model_edge();
        push(1'b1);   // after the edge
    endtask

    task automatic chk(string name, int id, bit post, logic [7:0] act, logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s txn %0d %s: got %02h expected %02h",
                     name, id, post ? "after-edge" : "mid-cycle", act, exp);
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (expq.size() == 0) return;
        e = expq.pop_front();
        chk("r4.aluA", e.id, e.post, if4.o_aluA, e.o4.a);
        chk("r4.aluB", e.id, e.post, if4.o_aluB, e.o4.b);
        chk("r4.bus",  e.id, e.post, bus4,       e.o4.bus);
        chk("r4.wrap", e.id, e.post, {7'd0, if4.o_wrap}, {7'd0, e.o4.w});
        chk("r4.zero", e.id, e.post, {4'd0, if4.o_zero}, {4'd0, e.o4.z});
        chk("r3.aluA", e.id, e.post, if3.o_aluA, e.o3.a);
        chk("r3.aluB", e.id, e.post, if3.o_aluB, e.o3.b);
        chk("r3.bus",  e.id, e.post, bus3,       e.o3.bus);
        chk("r3.wrap", e.id, e.post, {7'd0, if3.o_wrap}, {7'd0, e.o3.w});
        chk("r3.zero", e.id, e.post, {5'd0, if3.o_zero}, {4'd0, e.o3.z});
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk); #2;
            check_one();
            @(posedge clk); #1;
            check_one();
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst = 1'b1; clr = 1'b0; op = OP_NOP; ws = '0; d = '0;
        sa = '0; sb = '0; bs = '0; be = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 4; r++) m[k][r] = 0;
            mw[k] = 0;
        end
        @(negedge clk);
        @(negedge clk);

        // reset state, then loads and dual ALU reads
        cycle(1, 0, OP_NOP,  0, 0,    0, 1, 0, 0);
        cycle(0, 0, OP_LOAD, 2, 'h5A, 2, 3, 2, 0);
        cycle(0, 0, OP_LOAD, 3, 'hA5, 2, 3, 2, 0);
        cycle(0, 0, OP_NOP,  0, 0,    2, 3, 2, 0);
        // increment across the wrap point
        cycle(0, 0, OP_LOAD, 1, 'hFE, 1, 1, 1, 1);
        cycle(0, 0, OP_INC,  1, 0,    1, 1, 1, 1);
        cycle(0, 0, OP_INC,  1, 0,    1, 1, 1, 1);
        cycle(0, 0, OP_NOP,  1, 0,    1, 1, 1, 1);
        // decrement below zero, then clear overriding DEC
        cycle(0, 0, OP_DEC,  0, 0,    0, 0, 0, 0);
        cycle(0, 1, OP_DEC,  0, 0,    0, 0, 0, 0);
        cycle(0, 0, OP_NOP,  0, 0,    0, 0, 0, 0);
        // bus enable and select changes without an edge
        cycle(0, 0, OP_NOP,  0, 0,    2, 3, 2, 0);
        cycle(0, 0, OP_NOP,  0, 0,    2, 3, 2, 1);
        cycle(0, 0, OP_NOP,  0, 0,    2, 3, 3, 1);
        // reset beats a load; reset in the middle of a count
        cycle(1, 0, OP_LOAD, 3, 'h10, 3, 2, 3, 1);
        cycle(0, 0, OP_INC,  1, 0,    1, 0, 1, 1);
        cycle(0, 0, OP_INC,  1, 0,    1, 0, 1, 1);
        cycle(0, 0, OP_INC,  1, 0,    1, 0, 1, 1);
        cycle(1, 0, OP_INC,  1, 0,    1, 0, 1, 1);
        cycle(0, 0, OP_NOP,  1, 0,    1, 0, 1, 1);
        // index 3: real register in the 4-deep file, out of range in the 3-deep one
        cycle(0, 0, OP_LOAD, 3, 'h77, 3, 3, 3, 1);
        cycle(0, 0, OP_DEC,  3, 0,    3, 0, 3, 1);
        cycle(0, 0, OP_NOP,  3, 0,    3, 2, 3, 1);

        for (int i = 0; i < 250; i++) begin
            int dd;
            dd = ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 255 : 0)
                                             : int'($urandom_range(0, 255));
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                  op_e'($urandom_range(0, 3)), int'($urandom_range(0, 3)), dd,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending entries expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
